// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmit FSM states, default 2.08 MHz timing, parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_START     = 3'd2,
    ST_DATA      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_state_e;

  localparam int unsigned DEF_INHIBIT_CYCLES    = 208;
  localparam int unsigned DEF_START_HOLD_CYCLES = 42;
  localparam int unsigned DEF_TIMEOUT_CYCLES    = 31200;

  localparam int unsigned FRAME_W  = 10;
  localparam logic [3:0]  STOP_IDX = 4'd9;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Two-flop synchronizer for the PS/2 clock and data lines with a falling-edge pulse on clock.
module ps2_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic fall
);

  logic clk_p0, clk_p1, clk_p2;
  logic data_p0, data_p1;

  // Lines idle high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_p0  <= 1'b1;
      clk_p1  <= 1'b1;
      clk_p2  <= 1'b1;
      data_p0 <= 1'b1;
      data_p1 <= 1'b1;
    end else begin
      clk_p0  <= ps2_clk_in;
      clk_p1  <= clk_p0;
      clk_p2  <= clk_p1;
      data_p0 <= ps2_data_in;
      data_p1 <= data_p0;
    end
  end

  assign clk_sync  = clk_p1;
  assign data_sync = data_p1;
  assign fall      = clk_p2 & ~clk_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clocked-out frame, ack check.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES    = DEF_INHIBIT_CYCLES,
  parameter int unsigned START_HOLD_CYCLES = DEF_START_HOLD_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       ack_ok,
  output logic       err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(START_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e          state;
  logic [CNT_W-1:0]    cnt;
  logic [3:0]          idx;
  logic [FRAME_W-1:0]  frame;
  logic                data_bit;
  logic                clk_sync, data_sync, fall;
  logic                accept, timed_out, lines_idle;

  ps2_edge_sync u_sync (
    .clk         (clk),
    .reset_n     (reset_n),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .clk_sync    (clk_sync),
    .data_sync   (data_sync),
    .fall        (fall)
  );

  // tx_ready also drops during the done pulse so a new request waits one cycle.
  assign tx_ready   = (state == ST_IDLE) && !done;
  assign accept     = tx_valid && tx_ready;
  assign timed_out  = (cnt == TO_LAST) && !fall;
  assign lines_idle = clk_sync && data_sync;

  // Line drivers depend only on state so an asynchronous reset releases them at once.
  assign ps2_clk_oe  = (state == ST_INHIBIT) || (state == ST_START);
  assign ps2_data_oe = (state == ST_START) || ((state == ST_DATA) && data_bit);

  always_ff @(posedge clk) begin
    if (accept) frame <= {1'b1, odd_parity(tx_data), tx_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      idx      <= '0;
      data_bit <= 1'b0;
      done     <= 1'b0;
      ack_ok   <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state  <= ST_INHIBIT;
            cnt    <= '0;
            ack_ok <= 1'b0;
            err    <= 1'b0;
          end
        end
        ST_INHIBIT: begin
          if (cnt == INH_LAST) begin
            state <= ST_START;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_START: begin
          if (cnt == HOLD_LAST) begin
            state    <= ST_DATA;
            cnt      <= '0;
            idx      <= '0;
            data_bit <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (fall) begin
            cnt <= '0;
            if (idx == STOP_IDX) begin
              data_bit <= 1'b0;
              state    <= ST_ACK;
            end else begin
              data_bit <= ~frame[idx];
              idx      <= idx + 4'd1;
            end
          end else if (timed_out) begin
            state    <= ST_IDLE;
            data_bit <= 1'b0;
            done     <= 1'b1;
            err      <= 1'b1;
            ack_ok   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ACK: begin
          if (fall) begin
            cnt    <= '0;
            ack_ok <= ~data_sync;
            err    <= data_sync;
            state  <= ST_WAIT_IDLE;
          end else if (timed_out) begin
            state  <= ST_IDLE;
            done   <= 1'b1;
            err    <= 1'b1;
            ack_ok <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          if (lines_idle) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end else if (fall) begin
            cnt <= '0;
          end else if (timed_out) begin
            state  <= ST_IDLE;
            done   <= 1'b1;
            err    <= 1'b1;
            ack_ok <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the open-drain PS2 clock/data lines.
It is the outbound counterpart of the existing PS/2 receive path (shift register, frame state machine, decoder).
It runs on the 2.08 MHz internal-oscillator clock. It samples the device-generated PS2 clock and drives both lines only by pulling them low.

Parameters:
INHIBIT_CYCLES, 208, clock-low inhibit time before the request (100 us at 2.08 MHz)
START_HOLD_CYCLES, 42, cycles data is held low before clock is released (20 us)
TIMEOUT_CYCLES, 31200, maximum wait between device clock falling edges (15 ms); counter width is $clog2(TIMEOUT_CYCLES+1)

Ports:
clk  input  1  2.08 MHz system clock
reset_n  input  1  asynchronous, active-low reset
tx_data  input  8  command byte, sampled on accept
tx_valid  input  1  request to send tx_data
tx_ready  output  1  high only in IDLE; accept = tx_valid & tx_ready
ps2_clk_in  input  1  raw PS2 clock line (asynchronous)
ps2_data_in  input  1  raw PS2 data line (asynchronous)
ps2_clk_oe  output  1  1 = pull PS2 clock low; 0 = release
ps2_data_oe  output  1  1 = pull PS2 data low; 0 = release
done  output  1  one-cycle pulse when a transfer ends (success or failure)
ack_ok  output  1  valid with done: device acknowledged
err  output  1  valid with done: timeout or missing ack

Behaviour:
- Interface: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, done=0, ack_ok=0, err=0, state=IDLE, tx_ready=1.
- Reset asserted mid-transfer releases both lines immediately and asynchronously.
- Line inputs pass through a 2-FF synchronizer. `fall` is a one-cycle pulse on a synchronized 1->0 transition of the PS2 clock.
- Shift register: {stop=1, parity, tx_data[7:0]}, sent LSB first.
- Parity is odd: parity = ~^tx_data.
- IDLE: both oe=0. On accept, latch the frame, clear the counter and go to INHIBIT. Accept takes one cycle; accepting while the device is mid-frame is legal, because the inhibit aborts that frame.
- INHIBIT: clk_oe=1 for exactly INHIBIT_CYCLES cycles, then go to START.
- START: clk_oe=1 and data_oe=1 (start bit 0) for START_HOLD_CYCLES cycles, then release clk_oe and go to DATA with bit index 0.
- DATA: on each `fall`, set data_oe = ~frame[idx] and increment idx.
  - idx 0..7 carry the data bits and idx 8 carries parity.
  - On the fall at idx 9 (stop), data_oe=0 and go to ACK.
- ACK: on the next `fall`, sample synchronized data.
  - data 0 -> ack_ok=1.
  - data 1 -> err=1.
  - Either way go to WAIT_IDLE.
- WAIT_IDLE: wait until synchronized clock=1 and data=1, then pulse done for one cycle and return to IDLE. ack_ok and err hold their values until the next accept.
- Timeout: in DATA, ACK and WAIT_IDLE, a counter clears on every `fall` and increments otherwise.
  - Reaching TIMEOUT_CYCLES releases both lines, sets err=1 and ack_ok=0, pulses done and returns to IDLE.
  - If a `fall` arrives on the same cycle the counter reaches TIMEOUT_CYCLES, the `fall` wins.
- Invariant: ps2_clk_oe and ps2_data_oe are never driven from a state other than those listed above.
- The receive path must be held in reset (external) while tx_ready=0. This block only guarantees that tx_ready=0 throughout a transfer.

Decomposition:
- ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, START, DATA, ACK, WAIT_IDLE);
  - default timing constants for 2.08 MHz;
  - the odd_parity(byte) function.
- Sub-module ps2_edge_sync: 2-FF synchronizer for clock and data plus the falling-edge detect. It is reusable by the receive path.

Test Plan:
- Send tx_data=0xED against a device model -> data_oe pattern on successive falls = start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop released; model acks low -> done with ack_ok=1, err=0.
- Accept 0x00, then 0xFF, then 0x01 -> parity bits 1, 1, 0 respectively; tx_ready=0 from the accept cycle until the cycle after done.
- Measure the inhibit -> clk_oe=1 for exactly 208 cycles, then data_oe rises with clk_oe still 1 for 42 cycles, then clk_oe=0.
- Device never clocks after the request -> done pulses with err=1, ack_ok=0 exactly 31200 cycles after clk release; both oe=0.
- Device leaves data high at the ack clock -> done with err=1, ack_ok=0.
- Assert reset_n=0 during DATA bit 4 -> both oe drop to 0 asynchronously; after release, tx_ready=1 and the next 0xF4 transfer completes with ack_ok=1.
